floor_scroller: RTL and testbench



---
 rtl/floor_pkg.sv | 25 ++
 rtl/floor_lfsr.sv | 23 ++
 rtl/floor_scroller.sv | 150 +++++++++++++++
 tb/tb_floor_scroller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
// Shared types, constants and initial-layout helpers for the falling-floor scroller.
package floor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LfsrTaps = 16'h002D;
    localparam int unsigned ScreenHDefault = 480;

    function automatic int unsigned init_y(int unsigned idx, int unsigned screen_h,
                                           int unsigned num_floors);
        return idx * (screen_h / num_floors);
    endfunction

    function automatic int unsigned init_x(int unsigned idx, int unsigned slot_w,
                                           int unsigned x_step);
        return ((3 * idx + 1) % (1 << slot_w)) * x_step;
    endfunction

endpackage

// File: rtl/floor_lfsr.sv
// 16-bit Fibonacci LFSR used to pick respawn x slots; seeded on reset, never reaches zero.
module floor_lfsr
    import floor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LfsrSeed;
        end else if (en) begin
            lfsr_q <= {^(lfsr_q & LfsrTaps), lfsr_q[15:1]};
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/floor_scroller.sv
// Scrolls NUM_FLOORS floor records down one pixel per step, respawning them at random x slots.
// Optional: define FLOOR_AUTO_SPEEDUP_EN to shorten the step interval every 16 respawns.
module floor_scroller
    import floor_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned SCREEN_H   = ScreenHDefault,
    parameter int unsigned SLOT_W     = 4,
    parameter int unsigned X_STEP     = 40,
    parameter int unsigned CNT_W      = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      restart,
    input  logic [1:0]                level,
    output logic [NUM_FLOORS*X_W-1:0] floor_x,
    output logic [NUM_FLOORS*Y_W-1:0] floor_y,
    output logic [NUM_FLOORS-1:0]     floor_en,
    output logic                      respawn,
    output logic [CNT_W-1:0]          respawn_cnt,
    output logic [1:0]                state
);

    localparam int unsigned NumW = $clog2(NUM_FLOORS + 1);

    logic [15:0]           lfsr;
    state_e                state_q;
    logic [2:0]            div_q;
    logic                  respawn_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_next;
    logic [CNT_W:0]        cnt_sum;
    logic [NUM_FLOORS-1:0] wrap;
    logic [NumW-1:0]       wrap_num;
    logic [1:0]            eff_level;
    logic [2:0]            div_mask;
    logic                  step;
    logic                  reload;

    floor_lfsr u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .lfsr (lfsr)
    );

`ifdef FLOOR_AUTO_SPEEDUP_EN
    logic [3:0] boost;
    assign boost     = cnt_q[7:4];
    assign eff_level = (4'(level) > boost) ? level - boost[1:0] : 2'd0;
`else
    assign eff_level = level;
`endif

    assign div_mask = 3'((4'd1 << eff_level) - 4'd1);
    assign step     = (state_q == StRun) && tick && ((div_q & div_mask) == 3'd0);
    // IDLE keeps the floors pinned to the initial layout until the game starts.
    assign reload   = restart || (state_q == StIdle);

    always_comb begin
        wrap_num = '0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            wrap_num = wrap_num + NumW'(wrap[k]);
        end
    end

    assign cnt_sum  = {1'b0, cnt_q} + (CNT_W + 1)'(wrap_num);
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            respawn_q <= 1'b0;
            cnt_q     <= '0;
        end else if (restart) begin
            state_q   <= StIdle;
            div_q     <= '0;
            respawn_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            respawn_q <= step && (|wrap);
            case (state_q)
                StIdle: begin
                    div_q <= '0;
                    cnt_q <= '0;
                    if (start) state_q <= StRun;
                end
                StRun: begin
                    if (tick) div_q <= div_q + 3'd1;
                    if (step) cnt_q <= cnt_next;
                    if (pause) state_q <= StPause;
                end
                StPause: begin
                    if (pause) state_q <= StRun;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
        localparam logic [Y_W-1:0] InitY = Y_W'(init_y(i, SCREEN_H, NUM_FLOORS));
        localparam logic [X_W-1:0] InitX = X_W'(init_x(i, SLOT_W, X_STEP));
        localparam int unsigned    Rot   = (i * SLOT_W) % 16;

        logic [Y_W-1:0]    y_q;
        logic [X_W-1:0]    x_q;
        logic              en_q;
        logic [SLOT_W-1:0] slot;

        assign wrap[i] = (y_q == Y_W'(SCREEN_H - 1));
        // Each floor reads its own rotation of the LFSR so simultaneous wraps differ.
        assign slot    = SLOT_W'((lfsr >> Rot) | (lfsr << ((16 - Rot) % 16)));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_q  <= InitY;
                x_q  <= InitX;
                en_q <= 1'b1;
            end else if (reload) begin
                y_q  <= InitY;
                x_q  <= InitX;
                en_q <= 1'b1;
            end else if (step) begin
                if (wrap[i]) begin
                    y_q  <= '0;
                    x_q  <= X_W'(32'(slot) * X_STEP);
                    en_q <= 1'b1;
                end else begin
                    y_q <= y_q + Y_W'(1);
                end
            end
        end

        assign floor_y[i*Y_W +: Y_W] = y_q;
        assign floor_x[i*X_W +: X_W] = x_q;
        assign floor_en[i]           = en_q;
    end

    assign respawn     = respawn_q;
    assign respawn_cnt = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_floor_scroller.sv
// Self-checking bench for floor_scroller: directed table, corner sequences, random vs model.
module tb_floor_scroller;

    localparam int NF = 8;
    localparam int SH = 480;
    localparam int SW = 4;
    localparam int XS = 40;
    localparam int CW = 10;
    localparam int XW = 10;
    localparam int YW = 10;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b1;
    logic            tick    = 1'b0;
    logic            start   = 1'b0;
    logic            pause   = 1'b0;
    logic            restart = 1'b0;
    logic [1:0]      level   = 2'd0;
    logic [NF*XW-1:0] floor_x;
    logic [NF*YW-1:0] floor_y;
    logic [NF-1:0]   floor_en;
    logic            respawn;
    logic [CW-1:0]   respawn_cnt;
    logic [1:0]      state;

    floor_scroller #(
        .NUM_FLOORS(NF),
        .X_W       (XW),
        .Y_W       (YW),
        .SCREEN_H  (SH),
        .SLOT_W    (SW),
        .X_STEP    (XS),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start      (start),
        .pause      (pause),
        .restart    (restart),
        .level      (level),
        .floor_x    (floor_x),
        .floor_y    (floor_y),
        .floor_en   (floor_en),
        .respawn    (respawn),
        .respawn_cnt(respawn_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model state: game state 0/1/2, floor coordinates, divider, score, LFSR.
    int my[NF];
    int mx[NF];
    int mst, mdiv, mcnt, mresp, mlfsr;

    typedef struct {
        bit tk;
        bit st;
        bit ps;
        bit rs;
        int lvl;
        int rep;
        int exp_state;
        int exp_y0;
    } vec_t;

    function automatic int lfsr_next(int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic int slot_of(int l, int i);
        int r;
        int rot;
        r   = (i * SW) % 16;
        rot = ((l >> r) | (l << (16 - r))) & 16'hFFFF;
        return rot % (1 << SW);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare_all(string tag);
        for (int i = 0; i < NF; i++) begin
            check($sformatf("%s y[%0d]", tag, i), int'(floor_y[i*YW +: YW]), my[i]);
            check($sformatf("%s x[%0d]", tag, i), int'(floor_x[i*XW +: XW]), mx[i]);
            check($sformatf("%s en[%0d]", tag, i), int'(floor_en[i]), 1);
        end
        check({tag, " state"}, int'(state), mst);
        check({tag, " respawn"}, int'(respawn), mresp);
        check({tag, " respawn_cnt"}, int'(respawn_cnt), mcnt);
    endtask

    task automatic load_layout();
        for (int i = 0; i < NF; i++) begin
            my[i] = i * (SH / NF);
            mx[i] = ((3 * i + 1) % (1 << SW)) * XS;
        end
        mcnt  = 0;
        mdiv  = 0;
        mresp = 0;
    endtask

    task automatic drive(bit tk, bit st, bit ps, bit rs, int lvl);
        tick    = tk;
        start   = st;
        pause   = ps;
        restart = rs;
        level   = 2'(lvl);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, int'(level));
        load_layout();
        mst   = 0;
        mlfsr = 16'hACE1;
        #3;
        compare_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance the model by one clock from the current inputs, then compare after the edge.
    task automatic cycle(string tag);
        int  nst;
        int  wraps;
        int  e;
        bit  stp;
        nst = mst;
        if (restart) begin
            nst = 0;
            load_layout();
        end else if (mst == 0) begin
            load_layout();
            if (start) nst = 1;
        end else begin
`ifdef FLOOR_AUTO_SPEEDUP_EN
            e = int'(level) - ((mcnt / 16) % 16);
            if (e < 0) e = 0;
`else
            e = int'(level);
`endif
            stp   = (mst == 1) && tick && ((mdiv % (1 << e)) == 0);
            wraps = 0;
            if (stp) begin
                for (int i = 0; i < NF; i++) begin
                    if (my[i] == SH - 1) begin
                        my[i] = 0;
                        mx[i] = slot_of(mlfsr, i) * XS;
                        wraps++;
                    end else begin
                        my[i] = my[i] + 1;
                    end
                end
            end
            mresp = (wraps > 0) ? 1 : 0;
            mcnt  = (mcnt + wraps > (1 << CW) - 1) ? (1 << CW) - 1 : mcnt + wraps;
            if (mst == 1 && tick) mdiv = (mdiv + 1) % 8;
            if (pause) nst = (mst == 1) ? 2 : 1;
        end
        mst   = nst;
        mlfsr = lfsr_next(mlfsr);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        vec_t vecs[$];
        int   x7_exp;
        int   first;
        int   gap;
        int   prev;

        #2;
        do_reset();

        // tick, start, pause, restart, level, repeat, expected state, expected y0
        vecs.push_back('{0, 0, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 10, 1, 10});
        vecs.push_back('{0, 0, 1, 0, 0, 1, 2, 10});
        vecs.push_back('{1, 0, 0, 0, 0, 5, 2, 10});
        vecs.push_back('{0, 0, 1, 0, 0, 1, 1, 10});
        vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 11});
        vecs.push_back('{0, 0, 0, 0, 2, 3, 1, 11});
        vecs.push_back('{1, 0, 0, 0, 2, 8, 1, 13});
        vecs.push_back('{1, 0, 0, 0, 3, 8, 1, 14});
        vecs.push_back('{0, 1, 0, 0, 3, 1, 1, 14});

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].rep; r++) begin
                drive(vecs[k].tk, vecs[k].st, vecs[k].ps, vecs[k].rs, vecs[k].lvl);
                cycle("vec");
            end
            drive(0, 0, 0, 0, vecs[k].lvl);
            check($sformatf("vec%0d state", k), int'(state), vecs[k].exp_state);
            check($sformatf("vec%0d y0", k), int'(floor_y[0 +: YW]), vecs[k].exp_y0);
            check($sformatf("vec%0d y7", k), int'(floor_y[7*YW +: YW]), 420 + vecs[k].exp_y0);
        end

        // Floor 7 sits at 434; 45 more steps bring it to the last row, then it wraps.
        drive(1, 0, 0, 0, 0);
        repeat (45) cycle("climb");
        check("prewrap y7", int'(floor_y[7*YW +: YW]), 479);
        x7_exp = slot_of(mlfsr, 7) * XS;
        cycle("wrap");
        check("wrap y7", int'(floor_y[7*YW +: YW]), 0);
        check("wrap x7", int'(floor_x[7*XW +: XW]), x7_exp);
        check("wrap respawn", int'(respawn), 1);
        check("wrap cnt", int'(respawn_cnt), 1);
        drive(0, 0, 0, 0, 0);
        cycle("postwrap");
        check("postwrap respawn", int'(respawn), 0);
        check("postwrap cnt", int'(respawn_cnt), 1);

        // restart beats pause and a step tick in the same cycle.
        drive(1, 0, 1, 1, 0);
        cycle("restart");
        check("restart state", int'(state), 0);
        check("restart y0", int'(floor_y[0 +: YW]), 0);
        check("restart y7", int'(floor_y[7*YW +: YW]), 420);
        check("restart x5", int'(floor_x[5*XW +: XW]), 0);
        check("restart cnt", int'(respawn_cnt), 0);
        drive(0, 0, 0, 0, 0);
        cycle("idle");

        drive(0, 1, 0, 0, 0);
        cycle("rstart");
        for (int n = 0; n < 4000; n++) begin
            tick    = 1'($urandom_range(0, 1));
            start   = ($urandom_range(0, 19) == 0);
            pause   = ($urandom_range(0, 59) == 0);
            restart = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) level = 2'($urandom_range(0, 3));
            if (n == 2000) begin
                do_reset();
            end else begin
                cycle("rand");
            end
        end

`ifdef FLOOR_AUTO_SPEEDUP_EN
        do_reset();
        drive(0, 1, 0, 0, 0);
        cycle("sp");
        drive(1, 0, 0, 0, 0);
        for (int n = 0; n < 2000 && mcnt < 16; n++) cycle("sp");
        check("speedup cnt", int'(respawn_cnt), 16);
        level = 2'd3;
        first = -1;
        gap   = -1;
        prev  = int'(floor_y[0 +: YW]);
        for (int n = 0; n < 40 && gap < 0; n++) begin
            cycle("sp");
            if (int'(floor_y[0 +: YW]) != prev) begin
                if (first < 0) first = n;
                else gap = n - first;
                prev = int'(floor_y[0 +: YW]);
            end
        end
        check("speedup gap", gap, 4);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
